// File: rtl/ecc_flit_pkg.sv
// Shared GF(2^8) arithmetic and byte-to-group mapping helpers for the
// streaming flit ECC encoder.
package ecc_flit_pkg;

  localparam logic [7:0] GF_POLY = 8'h2B;

  function automatic logic [7:0] mul_alpha(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic int group_of(input int b, input int num_groups);
    return b % num_groups;
  endfunction

  // The first NUM_GROUPS trailing slots hit every group once, so they carry checks.
  function automatic logic is_check_slot(input int k, input int num_groups);
    return (k < num_groups);
  endfunction

  function automatic logic params_ok(input int flit_bytes, input int data_bytes,
                                     input int num_groups, input int beat_bytes);
    return (num_groups > 0) && (beat_bytes > 0) &&
           (data_bytes == flit_bytes - 2 * num_groups) &&
           (flit_bytes % beat_bytes == 0) &&
           (2 * num_groups <= beat_bytes);
  endfunction

endpackage

// File: rtl/ecc_flit_stream_encoder_absorb.sv
// Combinational Horner step: folds one beat's data bytes into the per-group
// check accumulators and parity registers.
module ecc_beat_absorb
  import ecc_flit_pkg::*;
#(
  parameter int NUM_GROUPS = 3,
  parameter int BEAT_BYTES = 32,
  parameter int CW         = 3
) (
  input  logic [8*NUM_GROUPS-1:0] acc_in,
  input  logic [8*NUM_GROUPS-1:0] par_in,
  input  logic [8*BEAT_BYTES-1:0] data,
  input  logic [CW-1:0]           beat,
  input  logic [BEAT_BYTES-1:0]   mask,
  output logic [8*NUM_GROUPS-1:0] acc_out,
  output logic [8*NUM_GROUPS-1:0] par_out
);

  // Bytes are absorbed in ascending flit order; group depends on the beat
  // index because BEAT_BYTES need not be a multiple of NUM_GROUPS.
  always_comb begin
    acc_out = acc_in;
    par_out = par_in;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (mask[j] && (group_of(int'(beat) * BEAT_BYTES + j, NUM_GROUPS) == g)) begin
          acc_out[8*g +: 8] = mul_alpha(acc_out[8*g +: 8]) ^ data[8*j +: 8];
          par_out[8*g +: 8] = par_out[8*g +: 8] ^ data[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ecc_flit_stream_encoder.sv
// Beat-streaming flit ECC encoder: accumulates interleaved check/parity per
// group and overwrites the trailing ECC byte slots of the final beat.
module ecc_flit_stream_encoder
  import ecc_flit_pkg::*;
#(
  parameter int FLIT_BYTES = 256,
  parameter int DATA_BYTES = 250,
  parameter int NUM_GROUPS = 3,
  parameter int BEAT_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ecc_en,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*BEAT_BYTES-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*BEAT_BYTES-1:0] m_data,
  output logic                    m_last,
  output logic                    framing_err
);

  localparam int BEATS = FLIT_BYTES / BEAT_BYTES;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam int LAST_BASE = (BEATS - 1) * BEAT_BYTES;

  if (!params_ok(FLIT_BYTES, DATA_BYTES, NUM_GROUPS, BEAT_BYTES)) begin : g_param_check
    $error("ecc_flit_stream_encoder: illegal parameter combination");
  end

  logic [CW-1:0]           beat_cnt;
  logic                    ecc_en_q;
  logic [8*NUM_GROUPS-1:0] acc_q, par_q, acc_base, par_base, acc_nxt, par_nxt;
  logic [BEAT_BYTES-1:0]   mask;
  logic [8*BEAT_BYTES-1:0] out_data;
  logic                    fire, first_beat, at_last, en_eff, insert, out_last, ferr;

  assign s_ready    = !m_valid || m_ready;
  assign fire       = s_valid && s_ready;
  assign first_beat = (beat_cnt == '0);
  assign at_last    = (beat_cnt == LAST_BEAT);
  assign en_eff     = first_beat ? ecc_en : ecc_en_q;
  assign acc_base   = first_beat ? '0 : acc_q;
  assign par_base   = first_beat ? '0 : par_q;
  assign insert     = at_last && en_eff;
  assign out_last   = at_last || s_last;
  assign ferr       = (s_last != at_last);

  always_comb begin
    mask = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      mask[j] = ((int'(beat_cnt) * BEAT_BYTES + j) < DATA_BYTES);
    end
  end

  ecc_beat_absorb #(
    .NUM_GROUPS(NUM_GROUPS),
    .BEAT_BYTES(BEAT_BYTES),
    .CW        (CW)
  ) u_absorb (
    .acc_in (acc_base),
    .par_in (par_base),
    .data   (s_data),
    .beat   (beat_cnt),
    .mask   (mask),
    .acc_out(acc_nxt),
    .par_out(par_nxt)
  );

  // The final Horner multiply by alpha is applied here, on the way out.
  always_comb begin
    out_data = s_data;
    if (insert) begin
      for (int k = 0; k < 2 * NUM_GROUPS; k++) begin
        out_data[8*(DATA_BYTES + k - LAST_BASE) +: 8] = is_check_slot(k, NUM_GROUPS) ?
          mul_alpha(acc_nxt[8*group_of(DATA_BYTES + k, NUM_GROUPS) +: 8]) :
          par_nxt[8*group_of(DATA_BYTES + k, NUM_GROUPS) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      ecc_en_q <= 1'b0;
      acc_q    <= '0;
      par_q    <= '0;
    end else if (fire) begin
      beat_cnt <= out_last ? '0 : beat_cnt + 1'b1;
      ecc_en_q <= en_eff;
      if (en_eff) begin
        acc_q <= acc_nxt;
        par_q <= par_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      framing_err <= 1'b0;
    end else if (fire) begin
      m_valid     <= 1'b1;
      m_data      <= out_data;
      m_last      <= out_last;
      framing_err <= ferr;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ecc_flit_stream_encoder.sv
// Directed bench for the streaming flit ECC encoder with a direct-form
// (power-of-alpha) reference model.
module tb_ecc_flit_stream_encoder;

  localparam int FB = 256;
  localparam int DB = 250;
  localparam int NG = 3;
  localparam int BB = 32;
  localparam int BEATS = FB / BB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ecc_en = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [8*BB-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [8*BB-1:0] m_data;
  logic            m_last;
  logic            framing_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]   cur [FB];
  logic [7:0]   exp_flit [FB];
  logic [255:0] exp_data_q[$], got_data_q[$];
  logic         exp_last_q[$], got_last_q[$], exp_ferr_q[$], got_ferr_q[$];
  logic         rand_ready = 1'b0;
  logic [255:0] last_beat = '0;
  logic [255:0] hold_data = '0;
  logic         hold_last = 1'b0, hold_ferr = 1'b0, holding = 1'b0;

  ecc_flit_stream_encoder #(
    .FLIT_BYTES(FB),
    .DATA_BYTES(DB),
    .NUM_GROUPS(NG),
    .BEAT_BYTES(BB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ecc_en     (ecc_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] ma(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h2B : 8'h00);
  endfunction

  // Reference: check_g = XOR of d * alpha^(K_g - p), evaluated per byte.
  task automatic build_expected(input logic en);
    int kg [NG];
    int pg [NG];
    logic [7:0] chk [NG];
    logic [7:0] par [NG];
    logic [7:0] t;
    for (int b = 0; b < FB; b++) exp_flit[b] = cur[b];
    for (int g = 0; g < NG; g++) begin
      kg[g] = 0; pg[g] = 0; chk[g] = 8'h00; par[g] = 8'h00;
    end
    for (int b = 0; b < DB; b++) kg[b % NG]++;
    for (int b = 0; b < DB; b++) begin
      t = cur[b];
      repeat (kg[b % NG] - pg[b % NG]) t = ma(t);
      chk[b % NG] ^= t;
      par[b % NG] ^= cur[b];
      pg[b % NG]++;
    end
    if (en) begin
      for (int k = 0; k < 2 * NG; k++) begin
        exp_flit[DB + k] = (k < NG) ? chk[(DB + k) % NG] : par[(DB + k) % NG];
      end
    end
  endtask

  task automatic expect_beats(input int n, input logic en, input logic mark_last,
                              input logic mark_ferr);
    logic [255:0] d;
    build_expected(en);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < BB; j++) d[8*j +: 8] = exp_flit[i*BB + j];
      exp_data_q.push_back(d);
      exp_last_q.push_back(mark_last && (i == n - 1));
      exp_ferr_q.push_back(mark_ferr && (i == n - 1));
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic l, input logic e);
    int budget = 0;
    s_data = d; s_last = l; ecc_en = e; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) checkOutput("ready_timeout", 256'(s_ready), 256'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic en0, input logic en_rest,
                               input int last_at, input logic check_latency);
    logic [255:0] d;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < BB; j++) d[8*j +: 8] = cur[i*BB + j];
      send_beat(d, (i == last_at), (i == 0) ? en0 : en_rest);
      if (check_latency && i == 0) checkOutput("latency_m_valid", 256'(m_valid), 256'(1));
    end
  endtask

  task automatic drain_and_compare(input string tag);
    int budget = 0;
    int n;
    while (got_data_q.size() < exp_data_q.size() && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    checkOutput({tag, "_count"}, 256'(got_data_q.size()), 256'(exp_data_q.size()));
    n = (got_data_q.size() < exp_data_q.size()) ? got_data_q.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_data"}, got_data_q[i], exp_data_q[i]);
      checkOutput({tag, "_last"}, 256'(got_last_q[i]), 256'(exp_last_q[i]));
      checkOutput({tag, "_ferr"}, 256'(got_ferr_q[i]), 256'(exp_ferr_q[i]));
    end
    last_beat = (got_data_q.size() > 0) ? got_data_q[$] : '0;
    got_data_q.delete(); got_last_q.delete(); got_ferr_q.delete();
    exp_data_q.delete(); exp_last_q.delete(); exp_ferr_q.delete();
    #1;
  endtask

  task automatic fill(input logic random_fill);
    for (int b = 0; b < FB; b++) cur[b] = random_fill ? 8'($urandom) : 8'h00;
  endtask

  // Output capture plus stability check while the sink stalls.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (holding) begin
        checkOutput("hold_data", m_data, hold_data);
        checkOutput("hold_last", 256'(m_last), 256'(hold_last));
        checkOutput("hold_ferr", 256'(framing_err), 256'(hold_ferr));
      end
      if (m_ready) begin
        got_data_q.push_back(m_data);
        got_last_q.push_back(m_last);
        got_ferr_q.push_back(framing_err);
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        hold_data = m_data; hold_last = m_last; hold_ferr = framing_err;
      end
    end else begin
      holding = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [255:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", 256'(m_valid), 256'(0));
    checkOutput("reset_m_data", m_data, 256'(0));
    checkOutput("reset_m_last", 256'(m_last), 256'(0));
    checkOutput("reset_ferr", 256'(framing_err), 256'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("reset_s_ready", 256'(s_ready), 256'(1));
    @(posedge clk);
    #1;

    fill(1'b0);
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b1);
    drain_and_compare("zero");
    checkOutput("zero_ecc", 256'(last_beat[255:208]), 256'(48'h000000000000));

    fill(1'b0); cur[249] = 8'h01;
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("b249");
    checkOutput("b249_ecc", 256'(last_beat[255:208]), 256'(48'h010000020000));

    fill(1'b0); cur[228] = 8'h01;
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("b228");
    checkOutput("b228_ecc", 256'(last_beat[255:208]), 256'(48'h0100002B0000));

    fill(1'b0); cur[247] = 8'h01;
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("b247");
    checkOutput("b247_ecc", 256'(last_beat[255:208]), 256'(48'h000001000002));

    fill(1'b1);
    for (int b = DB; b < FB; b++) cur[b] = 8'hA5;
    expect_beats(BEATS, 1'b0, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b0, 1'b0, BEATS - 1, 1'b0);
    drain_and_compare("bypass");
    checkOutput("bypass_tail", 256'(last_beat[255:208]), 256'(48'hA5A5A5A5A5A5));
    expect_beats(BEATS, 1'b0, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b0, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("bypass_toggle");
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b0, BEATS - 1, 1'b0);
    drain_and_compare("ecc_toggle");

    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      fill(1'b1);
      expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
      applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    end
    drain_and_compare("random");

    fill(1'b1);
    expect_beats(4, 1'b0, 1'b1, 1'b1);
    applyStimulus(4, 1'b1, 1'b1, 3, 1'b0);
    fill(1'b1);
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("framing");
    rand_ready = 1'b0;

    fill(1'b1);
    expect_beats(5, 1'b1, 1'b0, 1'b0);
    applyStimulus(5, 1'b1, 1'b1, -1, 1'b0);
    drain_and_compare("pre_reset");
    for (int j = 0; j < BB; j++) d[8*j +: 8] = cur[5*BB + j];
    s_data = d; s_last = 1'b0; ecc_en = 1'b1; s_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", 256'(m_valid), 256'(0));
    checkOutput("midrst_m_data", m_data, 256'(0));
    checkOutput("midrst_m_last", 256'(m_last), 256'(0));
    checkOutput("midrst_ferr", 256'(framing_err), 256'(0));
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(1'b1);
    expect_beats(BEATS, 1'b1, 1'b1, 1'b0);
    applyStimulus(BEATS, 1'b1, 1'b1, BEATS - 1, 1'b0);
    drain_and_compare("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
